// File: rtl/shift_pkg.sv
// Shared shift definitions: right-shifter FSM states and the
// shift-kind encoding also used by the left shifter and ALU decode.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam logic SHIFT_LOGICAL = 1'b0;
    localparam logic SHIFT_ARITH   = 1'b1;

endpackage

// File: rtl/right_shift_stage.sv
// One conditional shift step: shifts right by 2^k with a fill bit,
// or passes data through when the stage is not enabled.
module right_shift_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5,
    parameter int KW    = $clog2(DEPTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [KW-1:0]    k_i,
    input  logic             en_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int LW = $clog2(WIDTH);

    logic [WIDTH-1:0] cand [DEPTH];

    // Stages whose distance reaches WIDTH saturate to the fill bit.
    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        if (s >= LW) begin : g_all
            assign cand[s] = {WIDTH{fill_i}};
        end else begin : g_part
            localparam int SH = 1 << s;
            assign cand[s] = {{SH{fill_i}}, data_i[WIDTH-1:SH]};
        end
    end

    always_comb begin
        data_o = data_i;
        for (int s = 0; s < DEPTH; s++) begin
            if (en_i && (k_i == KW'(s))) begin
                data_o = cand[s];
            end
        end
    end

endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter resolving one shift-amount bit per clock,
// with valid/ready handshakes on operand and result.
module seq_right_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [DEPTH-1:0] in_shamt,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int KW = $clog2(DEPTH + 1);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [DEPTH-1:0] shamt_q, shamt_d;
    logic             fill_q, fill_d;
    logic             stage_en;
    logic [WIDTH-1:0] stage_out;

    always_comb begin
        stage_en = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            if (k_q == KW'(s)) begin
                stage_en = shamt_q[s];
            end
        end
    end

    right_shift_stage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .KW    (KW)
    ) u_stage (
        .data_i (work_q),
        .k_i    (k_q),
        .en_i   (stage_en),
        .fill_i (fill_q),
        .data_o (stage_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            work_q  <= '0;
            shamt_q <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            work_q  <= work_d;
            shamt_q <= shamt_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        work_d    = work_q;
        shamt_d   = shamt_q;
        fill_d    = fill_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = in_data;
                    shamt_d = in_shamt;
                    fill_d  = (in_arith == SHIFT_ARITH) & in_data[WIDTH-1];
                    k_d     = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = stage_out;
                k_d    = k_q + KW'(1);
                if (k_q == KW'(DEPTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = work_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Scoreboard bench for seq_right_shifter: directed cases, backpressure,
// mid-shift reset and randomized traffic against a >> / >>> model.
module tb_seq_right_shifter;

    localparam int W = 32;
    localparam int D = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [D-1:0] in_shamt;
    logic         in_arith;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    seq_right_shifter #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rmode  = 1;
    bit seen   = 1'b0;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];

    always @(posedge clk) cyc++;

    function automatic logic [W-1:0] model(input logic [W-1:0] d,
                                           input int sh, input bit ar);
        logic [W-1:0] r;
        if (ar) r = $signed(d) >>> sh;
        else    r = d >> sh;
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Monitor: drives out_ready per mode, then checks on handshakes.
    always @(negedge clk) begin
        case (rmode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (acc_q.size() == 0) check("spurious_valid", 1, 0);
                else check("latency", cyc - acc_q.pop_front(), D + 1);
            end
            if (out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                else check("out_data", out_data, exp_q.pop_front());
                check("in_ready_while_valid", in_ready, 0);
                seen = 1'b0;
            end
        end
    end

    // Called and returns at a negedge.
    task automatic send(input logic [W-1:0] d, input int sh, input bit ar);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = D'(sh);
        in_arith = ar;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 1, 0);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(d, sh, ar));
        acc_q.push_back(cyc);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shamt = D'($urandom);
        in_arith = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", out_valid, 1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_shamt = '0;
        in_arith = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        rmode = 1;
        send(32'h8000_0000, 31, 1'b0);
        drain();
        send(32'h8000_0000, 4, 1'b1);
        send(32'h7FFF_FFFF, 31, 1'b1);
        send(32'hDEAD_BEEF, 0, 1'b0);
        send(32'hDEAD_BEEF, 0, 1'b1);
        send(32'h8765_4321, 31, 1'b1);
        drain();

        // Backpressure with a competing operand on the input side
        rmode = 0;
        send(32'h1234_5678, 8, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'hAAAA_5555;
        in_shamt = D'(1);
        in_arith = 1'b1;
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 32'h0012_3456);
            check("bp_in_ready", in_ready, 0);
        end
        rmode = 1;
        send(32'hAAAA_5555, 1, 1'b1);
        drain();

        // Reset during stage 2
        send(32'hFFFF_0000, 8, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_out_valid", out_valid, 0);
            check("post_rst_out_data", out_data, 0);
        end
        check("post_rst_in_ready", in_ready, 1);
        send(32'h0000_00F0, 4, 1'b0);
        drain();

        rmode = 2;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send($urandom, int'($urandom_range(0, 31)), 1'($urandom));
        end
        drain();
        check("lat_q_left", acc_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
